// File: rtl/bcp_check_if.sv
// bcp_check_if: clause-in / classification-out bundle for bcp_check.
// master drives the clause inputs; slave is the checker side.
interface bcp_check_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic [3:0]       lit_present;
  logic [3:0]       clause_assign;
  logic [3:0]       clause_sat;
  logic [3:0]       unit_clause;
  logic [1:0]       unit_index;
  logic             satisfied;
  logic             conflict;
  logic             unresolved;
  logic             illegal;
  logic             out_valid;
  logic [CNT_W-1:0] unit_cnt;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output in_valid, lit_present, clause_assign, clause_sat,
    input  unit_clause, unit_index, satisfied, conflict, unresolved, illegal,
    input  out_valid, unit_cnt, conflict_cnt
  );

  modport slave (
    input  in_valid, lit_present, clause_assign, clause_sat,
    output unit_clause, unit_index, satisfied, conflict, unresolved, illegal,
    output out_valid, unit_cnt, conflict_cnt
  );
endinterface

// File: rtl/bcp_check.sv
// bcp_check: classifies one 4-literal clause per cycle as satisfied, conflict,
// unit or unresolved for boolean constraint propagation. Registered outputs,
// latency 1, no backpressure.
// Optional statistics counters are built when BCP_CHECK_STATS_EN is defined;
// otherwise unit_cnt/conflict_cnt are tied to 0.
// The interface CNT_W must match this module's CNT_W.
module bcp_check #(
  parameter int unsigned NUM_LITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bcp_check_if.slave    bus
);

  logic [3:0] w_true;
  logic [3:0] w_free;
  logic [2:0] w_free_cnt;
  logic [1:0] w_free_idx;
  logic       w_any_true;
  logic       w_illegal;
  logic       w_unit;
  logic       w_conflict;
  logic       w_unresolved;

  logic [3:0] r_unit_clause;
  logic [1:0] r_unit_index;
  logic       r_satisfied;
  logic       r_conflict;
  logic       r_unresolved;
  logic       r_illegal;
  logic       r_out_valid;

  // Per-literal evaluation; absent slots contribute nothing. A literal that is
  // both assigned-false and sat counts as true (and is flagged illegal).
  always_comb begin
    w_true     = bus.lit_present & bus.clause_sat;
    w_free     = bus.lit_present & ~bus.clause_assign & ~bus.clause_sat;
    w_illegal  = |(bus.lit_present & bus.clause_assign & bus.clause_sat);
    w_any_true = |w_true;
    w_free_cnt = 3'd0;
    w_free_idx = 2'd0;
    for (int i = 0; i < NUM_LITS; i++) begin
      w_free_cnt = w_free_cnt + 3'(w_free[i]);
      if (w_free[i]) w_free_idx = 2'(i);
    end
    w_unit       = !w_any_true && (w_free_cnt == 3'd1);
    w_conflict   = !w_any_true && (w_free_cnt == 3'd0);
    w_unresolved = !w_any_true && (w_free_cnt >= 3'd2);
  end

  // Result registers: load on in_valid, hold otherwise; reset wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_unit_clause <= 4'd0;
      r_unit_index  <= 2'd0;
      r_satisfied   <= 1'b0;
      r_conflict    <= 1'b0;
      r_unresolved  <= 1'b0;
      r_illegal     <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_unit_clause <= w_unit ? w_free : 4'd0;
        r_unit_index  <= w_unit ? w_free_idx : 2'd0;
        r_satisfied   <= w_any_true;
        r_conflict    <= w_conflict;
        r_unresolved  <= w_unresolved;
        r_illegal     <= w_illegal;
      end
    end
  end

  assign bus.unit_clause = r_unit_clause;
  assign bus.unit_index  = r_unit_index;
  assign bus.satisfied   = r_satisfied;
  assign bus.conflict    = r_conflict;
  assign bus.unresolved  = r_unresolved;
  assign bus.illegal     = r_illegal;
  assign bus.out_valid   = r_out_valid;

`ifdef BCP_CHECK_STATS_EN
  logic [CNT_W-1:0] r_unit_cnt;
  logic [CNT_W-1:0] r_conflict_cnt;

  // Saturating event counters for unit and conflict results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_unit_cnt     <= '0;
      r_conflict_cnt <= '0;
    end else if (bus.in_valid) begin
      if (w_unit && !(&r_unit_cnt))         r_unit_cnt     <= r_unit_cnt + 1'b1;
      if (w_conflict && !(&r_conflict_cnt)) r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign bus.unit_cnt     = r_unit_cnt;
  assign bus.conflict_cnt = r_conflict_cnt;
`else
  assign bus.unit_cnt     = {CNT_W{1'b0}};
  assign bus.conflict_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_bcp_check.sv
// tb_bcp_check: directed and random clauses against a counting reference model.
module tb_bcp_check;

`ifdef BCP_CHECK_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  bcp_check_if #(.CNT_W(16)) bif ();

  bcp_check #(.NUM_LITS(4), .CNT_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state
  logic [3:0] e_unit;
  logic [1:0] e_idx;
  logic       e_sat, e_conf, e_unres, e_ill, e_ov;
  int         e_ucnt, e_ccnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: classify by counting true/free literals directly.
  task automatic model(input logic [3:0] p, input logic [3:0] a, input logic [3:0] s);
    int n_true, n_free, k;
    n_true = 0; n_free = 0; k = 0;
    e_ill = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (s[i]) begin
          n_true++;
          if (a[i]) e_ill = 1'b1;
        end else if (!a[i]) begin
          n_free++;
          k = i;
        end
      end
    end
    e_sat   = (n_true > 0);
    e_conf  = (n_true == 0) && (n_free == 0);
    e_unres = (n_true == 0) && (n_free >= 2);
    e_unit  = 4'd0;
    e_idx   = 2'd0;
    if (n_true == 0 && n_free == 1) begin
      e_unit = 4'(1 << k);
      e_idx  = 2'(k);
      if (StatsEn && e_ucnt < 65535) e_ucnt++;
    end
    if (e_conf && StatsEn && e_ccnt < 65535) e_ccnt++;
  endtask

  // One clock: drive inputs, advance, update model, optionally compare.
  task automatic step(input logic r, input logic v, input logic [3:0] p,
                      input logic [3:0] a, input logic [3:0] s, input bit chk);
    rst               = r;
    bif.in_valid      = v;
    bif.lit_present   = p;
    bif.clause_assign = a;
    bif.clause_sat    = s;
    @(posedge clk);
    #1;
    if (r) begin
      e_unit = 0; e_idx = 0; e_sat = 0; e_conf = 0; e_unres = 0; e_ill = 0;
      e_ov = 0; e_ucnt = 0; e_ccnt = 0;
    end else begin
      e_ov = v;
      if (v) model(p, a, s);
    end
    if (chk) begin
      check("unit_clause", 32'(bif.unit_clause), 32'(e_unit));
      check("unit_index", 32'(bif.unit_index), 32'(e_idx));
      check("flags{sat,conf,unres,ill}",
            32'({bif.satisfied, bif.conflict, bif.unresolved, bif.illegal}),
            32'({e_sat, e_conf, e_unres, e_ill}));
      check("out_valid", 32'(bif.out_valid), 32'(e_ov));
      check("unit_cnt", 32'(bif.unit_cnt), 32'(e_ucnt));
      check("conflict_cnt", 32'(bif.conflict_cnt), 32'(e_ccnt));
      if (bif.out_valid)
        check("one_class", 32'(int'(bif.satisfied) + int'(bif.conflict) +
              int'(bif.unresolved) + int'(bif.unit_clause != 4'd0)), 32'd1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    e_ucnt = 0; e_ccnt = 0;
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.lit_present = 4'd0;
    bif.clause_assign = 4'd0; bif.clause_sat = 4'd0;

    // Reset state, reset overriding in_valid
    step(1, 0, 4'h0, 4'h0, 4'h0, 1);
    step(1, 1, 4'hF, 4'hF, 4'h0, 1);

    // Directed vectors
    step(0, 1, 4'b1111, 4'b1011, 4'b0000, 1);  // unit at slot 2
    check("dir_unit_idx2", 32'(bif.unit_index), 32'd2);
    step(0, 1, 4'b1111, 4'b1111, 4'b0000, 1);  // conflict
    check("dir_conflict", 32'(bif.conflict), 32'd1);
    step(0, 1, 4'b0111, 4'b0011, 4'b1000, 1);  // absent slot 3 ignored -> unit 0100
    check("dir_absent_unit", 32'(bif.unit_clause), 32'h4);
    step(0, 1, 4'b1111, 4'b0000, 4'b0001, 1);  // satisfied
    step(0, 1, 4'b1111, 4'b0001, 4'b0001, 1);  // satisfied + illegal
    check("dir_illegal", 32'(bif.illegal), 32'd1);
    step(0, 1, 4'b1111, 4'b0011, 4'b0000, 1);  // unresolved
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 1);  // empty clause -> conflict
    step(0, 0, 4'b1111, 4'b0000, 4'b1111, 1);  // idle: hold, out_valid low
    step(0, 1, 4'b1000, 4'b0000, 4'b0000, 1);  // unit at slot 3

    // Mid-stream reset discards in-flight result
    step(0, 1, 4'b1111, 4'b1110, 4'b0000, 1);
    step(1, 1, 4'b1111, 4'b1111, 4'b0000, 1);
    step(0, 1, 4'b1111, 4'b1101, 4'b0000, 1);
    check("post_rst_valid", 32'(bif.out_valid), 32'd1);

    // Random stream, mostly valid, occasional reset
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0), 1);
    end

    // Counter saturation: stream unit clauses past all-ones
    if (StatsEn) begin
      for (int n = 0; n < 70000 && e_ucnt < 65535; n++)
        step(0, 1, 4'b1111, 4'b0111, 4'b0000, 0);
      step(0, 1, 4'b1111, 4'b1110, 4'b0000, 1);
      check("unit_cnt_sat", 32'(bif.unit_cnt), 32'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcp_check.md
BCP_CHECK -- requirements
Module: bcp_check

Interface
REQ-001 Parameter NUM_LITS, default 4, number of literal slots per clause; only 4 is supported.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 IN_VALID  input  1  qualifies the clause inputs for this cycle.
REQ-006 LIT_PRESENT  input  4  bit i=1: literal slot i exists in the clause.
REQ-007 CLAUSE_ASSIGN  input  4  bit i=1: literal i evaluates false under the current assignment.
REQ-008 CLAUSE_SAT  input  4  bit i=1: literal i evaluates true under the current assignment.
REQ-009 UNIT_CLAUSE  output  4  one-hot; marks the single free literal of a unit clause, else 0.
REQ-010 UNIT_INDEX  output  2  binary index of the UNIT_CLAUSE bit; 0 when not unit.
REQ-011 SATISFIED, CONFLICT, UNRESOLVED, ILLEGAL  output  1 each  clause classification flags.
REQ-012 OUT_VALID  output  1  one-cycle pulse; marks a new classification.
REQ-013 UNIT_CNT, CONFLICT_CNT  output  CNT_W each  statistics counters.

Function
REQ-014 Absent slots (LIT_PRESENT=0) shall be ignored completely.
REQ-015 A present literal i shall be: true if CLAUSE_SAT[i]=1; false if CLAUSE_ASSIGN[i]=1 and CLAUSE_SAT[i]=0; free otherwise.
REQ-016 A present literal with both CLAUSE_ASSIGN[i] and CLAUSE_SAT[i] set shall count as true and shall set ILLEGAL.
REQ-017 Any true literal: SATISFIED=1; UNIT_CLAUSE=0, CONFLICT=0, UNRESOLVED=0.
REQ-018 No true literal and zero free literals (includes LIT_PRESENT=0): CONFLICT=1.
REQ-019 No true literal and exactly one free literal at slot k: UNIT_CLAUSE bit k=1 and UNIT_INDEX=k.
REQ-020 No true literal and two or more free literals: UNRESOLVED=1, UNIT_CLAUSE=0.
REQ-021 Exactly one of SATISFIED, CONFLICT, UNRESOLVED, or a nonzero UNIT_CLAUSE shall hold in every valid result.
REQ-022 Outputs shall be registered, with latency 1 cycle: inputs sampled at edge N with IN_VALID=1 drive outputs and OUT_VALID=1 after edge N.
REQ-023 With IN_VALID=0, classification outputs shall hold their last values and OUT_VALID shall be 0.
REQ-024 Back-to-back IN_VALID cycles shall each produce a result with no bubbles; there is no backpressure.
REQ-025 UNIT_CNT and CONFLICT_CNT shall increment by 1 per valid unit or conflict result, respectively.
REQ-026 Both counters shall saturate at all-ones.

Reset
REQ-027 RST=1 at a clock edge shall clear all outputs and counters to 0, overriding IN_VALID in the same cycle.
REQ-028 Reset during a stream shall discard the in-flight result; the first result after RST deasserts comes from the first IN_VALID sampled with RST=0.

Configuration
REQ-029 Macro BCP_CHECK_STATS_EN defined: UNIT_CNT and CONFLICT_CNT shall be implemented per REQ-025 and REQ-026.
REQ-030 Macro BCP_CHECK_STATS_EN undefined: no counter registers shall exist, and UNIT_CNT and CONFLICT_CNT shall be constant 0.
REQ-031 Classification behaviour shall be identical with and without BCP_CHECK_STATS_EN.

Verification
REQ-032 PRESENT=1111, ASSIGN=1011, SAT=0000 -> next cycle UNIT_CLAUSE=0100, UNIT_INDEX=2, OUT_VALID=1.
REQ-033 PRESENT=1111, ASSIGN=1111, SAT=0000 -> CONFLICT=1, UNIT_CLAUSE=0000; CONFLICT_CNT 0->1 with STATS_EN.
REQ-034 PRESENT=0111, ASSIGN=0011, SAT=1000 -> UNIT_CLAUSE=0100 (slot 3 ignored); PRESENT=1111, SAT=0001 -> SATISFIED=1.
REQ-035 PRESENT=1111, ASSIGN=0001, SAT=0001 -> SATISFIED=1, ILLEGAL=1; ASSIGN=0011, SAT=0000 -> UNRESOLVED=1.
REQ-036 IN_VALID held 1 for 3 cycles, RST=1 on the 2nd edge -> all outputs 0 after that edge; the 3rd input produces a valid result.
REQ-037 With STATS_EN, preload UNIT_CNT to 16'hFFFF via a unit stream, apply one more unit -> UNIT_CNT stays 16'hFFFF.
